// File: rtl/memory_bus_pkg.sv
// Shared types for the memory bus bridge: FSM states, access sizes, fault causes
// and the registered bus request payload.
package memory_bus_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned BUS_ADDR_W = 30;
   localparam int unsigned BE_W       = 4;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUS     = 2'b01,
      RESPOND = 2'b10
   } bridge_state_e;

   // Also consumed by the controller's debug/exception logic.
   typedef enum logic [1:0] {
      FAULT_NONE       = 2'b00,
      FAULT_MISALIGNED = 2'b01,
      FAULT_ACCESS     = 2'b10,
      FAULT_TIMEOUT    = 2'b11
   } fault_cause_e;

   typedef struct packed {
      logic                  write;
      logic [BUS_ADDR_W-1:0] addr;
      logic [BE_W-1:0]       be;
      logic [DATA_W-1:0]     wdata;
   } bus_req_t;

endpackage

// File: rtl/memory_lane_encoder.sv
// Combinational lane encoder: byte enables, replicated store data and
// alignment/legality flags from access size and low address bits.
module memory_lane_encoder
   import memory_bus_pkg::*;
(
   input  logic [1:0]        size_i,
   input  logic [1:0]        addr_lo_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [BE_W-1:0]   byte_enable_c_o,
   output logic [DATA_W-1:0] data_c_o,
   output logic              misaligned_c_o,
   output logic              illegal_c_o
);

   // Replicating narrow data lets the slave pick any lane without a shifter.
   always_comb begin
      byte_enable_c_o = '0;
      data_c_o        = data_i;
      misaligned_c_o  = 1'b0;
      illegal_c_o     = 1'b0;
      case (size_i)
         MEM_BYTE: begin
            byte_enable_c_o = 4'b0001 << addr_lo_i;
            data_c_o        = {4{data_i[7:0]}};
         end
         MEM_HALF: begin
            byte_enable_c_o = 4'b0011 << addr_lo_i;
            data_c_o        = {2{data_i[15:0]}};
            misaligned_c_o  = addr_lo_i[0];
         end
         MEM_WORD: begin
            byte_enable_c_o = 4'b1111;
            misaligned_c_o  = |addr_lo_i;
         end
         default: begin
            illegal_c_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/memory_bus_bridge.sv
// Bridge from the core's memory handshake to a single-master req/ack system bus,
// with alignment checking, lane placement and an acknowledge timeout.
module memory_bus_bridge
   import memory_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memory_enable,
   input  logic                  memory_command,
   input  logic [31:0]           memory_address,
   input  logic [1:0]            memory_size,
   input  logic [DATA_W-1:0]     memory_write_data,
   output logic                  memory_ready,
   output logic                  memory_valid,
   output logic [DATA_W-1:0]     memory_read_data,
   output logic                  memory_fault,
   output logic [1:0]            memory_fault_cause,
   output logic                  bus_request,
   output logic                  bus_write,
   output logic [BUS_ADDR_W-1:0] bus_address,
   output logic [BE_W-1:0]       bus_byte_enable,
   output logic [DATA_W-1:0]     bus_write_data,
   input  logic                  bus_acknowledge,
   input  logic                  bus_error,
   input  logic [DATA_W-1:0]     bus_read_data
);

   localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   bridge_state_e     state_q, state_d;
   bus_req_t          req_q, req_d;
   logic              bus_request_q, bus_request_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic              fault_q, fault_d;
   fault_cause_e      cause_q, cause_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [BE_W-1:0]   enc_be_c;
   logic [DATA_W-1:0] enc_wdata_c;
   logic              enc_misaligned_c;
   logic              enc_illegal_c;

   memory_lane_encoder u_lane_encoder (
      .size_i          (memory_size),
      .addr_lo_i       (memory_address[1:0]),
      .data_i          (memory_write_data),
      .byte_enable_c_o (enc_be_c),
      .data_c_o        (enc_wdata_c),
      .misaligned_c_o  (enc_misaligned_c),
      .illegal_c_o     (enc_illegal_c)
   );

   // State register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         req_q         <= '0;
         bus_request_q <= 1'b0;
         count_q       <= '0;
         ready_q       <= 1'b1;
         valid_q       <= 1'b0;
         fault_q       <= 1'b0;
         cause_q       <= FAULT_NONE;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         bus_request_q <= bus_request_d;
         count_q       <= count_d;
         ready_q       <= ready_d;
         valid_q       <= valid_d;
         fault_q       <= fault_d;
         cause_q       <= cause_d;
         rdata_q       <= rdata_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      bus_request_d = bus_request_q;
      count_d       = count_q;
      fault_d       = fault_q;
      cause_d       = cause_q;
      rdata_d       = rdata_q;

      case (state_q)
         IDLE: begin
            if (memory_enable) begin
               count_d = '0;
               if (enc_illegal_c) begin
                  state_d = RESPOND;
                  fault_d = 1'b1;
                  cause_d = FAULT_ACCESS;
               end else if (enc_misaligned_c) begin
                  state_d = RESPOND;
                  fault_d = 1'b1;
                  cause_d = FAULT_MISALIGNED;
               end else begin
                  state_d       = BUS;
                  bus_request_d = 1'b1;
                  fault_d       = 1'b0;
                  cause_d       = FAULT_NONE;
                  req_d.write   = memory_command;
                  req_d.addr    = memory_address[31:2];
                  req_d.be      = enc_be_c;
                  req_d.wdata   = enc_wdata_c;
               end
            end
         end
         BUS: begin
            // An ack on the limit cycle takes priority over the timeout.
            if (bus_acknowledge) begin
               state_d       = RESPOND;
               bus_request_d = 1'b0;
               if (!req_q.write) begin
                  rdata_d = bus_read_data;
               end
               if (bus_error) begin
                  fault_d = 1'b1;
                  cause_d = FAULT_ACCESS;
               end
            end else if (count_q == CNT_LIMIT) begin
               state_d       = RESPOND;
               bus_request_d = 1'b0;
               fault_d       = 1'b1;
               cause_d       = FAULT_TIMEOUT;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d       = IDLE;
            bus_request_d = 1'b0;
         end
      endcase

      ready_d = (state_d == IDLE);
      valid_d = (state_d == RESPOND);
   end

   assign memory_ready       = ready_q;
   assign memory_valid       = valid_q;
   assign memory_read_data   = rdata_q;
   assign memory_fault       = fault_q;
   assign memory_fault_cause = cause_q;
   assign bus_request        = bus_request_q;
   assign bus_write          = req_q.write;
   assign bus_address        = req_q.addr;
   assign bus_byte_enable    = req_q.be;
   assign bus_write_data     = req_q.wdata;

endmodule

// File: tb/tb_memory_bus_bridge.sv
// Self-checking bench for memory_bus_bridge: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_memory_bus_bridge;

   localparam int TIMEOUT = 8;

   logic        clk;
   logic        reset;
   logic        memory_enable;
   logic        memory_command;
   logic [31:0] memory_address;
   logic [1:0]  memory_size;
   logic [31:0] memory_write_data;
   logic        memory_ready;
   logic        memory_valid;
   logic [31:0] memory_read_data;
   logic        memory_fault;
   logic [1:0]  memory_fault_cause;
   logic        bus_request;
   logic        bus_write;
   logic [29:0] bus_address;
   logic [3:0]  bus_byte_enable;
   logic [31:0] bus_write_data;
   logic        bus_acknowledge;
   logic        bus_error;
   logic [31:0] bus_read_data;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_rd = '0;

   memory_bus_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk                (clk),
      .reset              (reset),
      .memory_enable      (memory_enable),
      .memory_command     (memory_command),
      .memory_address     (memory_address),
      .memory_size        (memory_size),
      .memory_write_data  (memory_write_data),
      .memory_ready       (memory_ready),
      .memory_valid       (memory_valid),
      .memory_read_data   (memory_read_data),
      .memory_fault       (memory_fault),
      .memory_fault_cause (memory_fault_cause),
      .bus_request        (bus_request),
      .bus_write          (bus_write),
      .bus_address        (bus_address),
      .bus_byte_enable    (bus_byte_enable),
      .bus_write_data     (bus_write_data),
      .bus_acknowledge    (bus_acknowledge),
      .bus_error          (bus_error),
      .bus_read_data      (bus_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one access and checks it cycle by cycle against the model.
   // ack_wait = number of unacked request cycles before the ack (>= TIMEOUT means never).
   task automatic run_txn(input bit cmd, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input int ack_wait, input bit err,
                          input logic [31:0] sdata, input bit hold_en);
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [1:0]  exp_cause;
      bit          exp_fault;
      int          req_cycles;
      int          valid_k;
      int          w;

      exp_be = 4'hF;
      exp_wd = wdata;
      if (size == 2'd0) begin
         exp_be = 4'(1 << addr[1:0]);
         exp_wd = {24'd0, wdata[7:0]} * 32'h0101_0101;
      end else if (size == 2'd1) begin
         exp_be = 4'(3 << addr[1:0]);
         exp_wd = {16'd0, wdata[15:0]} * 32'h0001_0001;
      end

      if (size == 2'd3) begin
         exp_fault = 1'b1; exp_cause = 2'd2; req_cycles = 0;
      end else if ((size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0)) begin
         exp_fault = 1'b1; exp_cause = 2'd1; req_cycles = 0;
      end else if (ack_wait < TIMEOUT) begin
         req_cycles = ack_wait + 1;
         exp_fault  = err;
         exp_cause  = err ? 2'd2 : 2'd0;
         if (!cmd) model_rd = sdata;
      end else begin
         req_cycles = TIMEOUT; exp_fault = 1'b1; exp_cause = 2'd3;
      end
      valid_k = (req_cycles == 0) ? 1 : req_cycles + 1;

      w = 0;
      while (!memory_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check_eq("ready_before_accept", 32'(memory_ready), 32'd1);

      memory_enable     = 1'b1;
      memory_command    = cmd;
      memory_address    = addr;
      memory_size       = size;
      memory_write_data = wdata;
      bus_acknowledge   = 1'($urandom);
      bus_error         = 1'($urandom);
      bus_read_data     = $urandom;

      for (int k = 1; k <= valid_k + 1; k++) begin
         @(negedge clk);
         if (!hold_en) memory_enable = 1'b0;
         check_eq("bus_request", 32'(bus_request), 32'(k <= req_cycles));
         if (k <= req_cycles) begin
            check_eq("bus_write", 32'(bus_write), 32'(cmd));
            check_eq("bus_address", 32'(bus_address), 32'(addr[31:2]));
            check_eq("bus_byte_enable", 32'(bus_byte_enable), 32'(exp_be));
            if (cmd) check_eq("bus_write_data", bus_write_data, exp_wd);
         end
         check_eq("memory_valid", 32'(memory_valid), 32'(k == valid_k));
         check_eq("memory_ready", 32'(memory_ready), 32'(k > valid_k));
         if (k == valid_k) begin
            check_eq("memory_fault", 32'(memory_fault), 32'(exp_fault));
            check_eq("fault_cause", 32'(memory_fault_cause), 32'(exp_cause));
            check_eq("read_data", memory_read_data, model_rd);
         end
         if (k <= req_cycles && (k - 1) == ack_wait) begin
            bus_acknowledge = 1'b1;
            bus_error       = err;
            bus_read_data   = sdata;
         end else if (k <= req_cycles) begin
            bus_acknowledge = 1'b0;
            bus_error       = 1'($urandom);
            bus_read_data   = $urandom;
         end else begin
            bus_acknowledge = 1'($urandom);
            bus_error       = 1'($urandom);
            bus_read_data   = $urandom;
         end
      end
      memory_enable = 1'b0;
   endtask

   initial begin
      reset             = 1'b0;
      memory_enable     = 1'b0;
      memory_command    = 1'b0;
      memory_address    = '0;
      memory_size       = 2'd2;
      memory_write_data = '0;
      bus_acknowledge   = 1'b0;
      bus_error         = 1'b0;
      bus_read_data     = '0;

      repeat (2) @(negedge clk);
      check_eq("rst_ready", 32'(memory_ready), 32'd1);
      check_eq("rst_valid", 32'(memory_valid), 32'd0);
      check_eq("rst_fault", 32'(memory_fault), 32'd0);
      check_eq("rst_cause", 32'(memory_fault_cause), 32'd0);
      check_eq("rst_read_data", memory_read_data, 32'd0);
      check_eq("rst_request", 32'(bus_request), 32'd0);
      check_eq("rst_write", 32'(bus_write), 32'd0);
      check_eq("rst_address", 32'(bus_address), 32'd0);
      check_eq("rst_byte_enable", 32'(bus_byte_enable), 32'd0);
      check_eq("rst_write_data", bus_write_data, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_txn(1'b0, 32'h0000_1000, 2'd2, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      run_txn(1'b1, 32'h0000_2003, 2'd0, 32'h0000_00A5, 3, 1'b0, 32'h0, 1'b1);
      check_eq("no_second_request", 32'(bus_request), 32'd0);
      run_txn(1'b0, 32'h0000_3001, 2'd1, 32'h0, 0, 1'b0, 32'h0, 1'b0);
      run_txn(1'b0, 32'h0000_0100, 2'd2, 32'h0, 1000, 1'b0, 32'h1234_5678, 1'b0);
      run_txn(1'b0, 32'h0000_0104, 2'd2, 32'h0, 1, 1'b0, 32'hCAFE_F00D, 1'b0);
      run_txn(1'b1, 32'h0000_0200, 2'd2, 32'h5555_AAAA, 2, 1'b1, 32'hFFFF_FFFF, 1'b0);
      run_txn(1'b0, 32'h0000_0300, 2'd2, 32'h0, TIMEOUT - 1, 1'b0, 32'h0BAD_CAFE, 1'b0);
      run_txn(1'b0, 32'h0000_0302, 2'd1, 32'h0, 0, 1'b1, 32'h7777_8888, 1'b0);
      run_txn(1'b1, 32'h0000_0303, 2'd3, 32'h0, 0, 1'b0, 32'h0, 1'b0);

      // Asynchronous reset during the second unacked BUS cycle.
      memory_enable   = 1'b1;
      memory_command  = 1'b0;
      memory_address  = 32'h0000_0040;
      memory_size     = 2'd2;
      bus_acknowledge = 1'b0;
      @(negedge clk);
      memory_enable = 1'b0;
      @(negedge clk);
      check_eq("pre_reset_request", 32'(bus_request), 32'd1);
      #1 reset = 1'b0;
      #1;
      check_eq("async_reset_request", 32'(bus_request), 32'd0);
      check_eq("async_reset_ready", 32'(memory_ready), 32'd1);
      model_rd = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("reset_no_valid", 32'(memory_valid), 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      check_eq("post_reset_ready", 32'(memory_ready), 32'd1);
      run_txn(1'b0, 32'h0000_0080, 2'd2, 32'h0, 0, 1'b0, 32'h1357_9BDF, 1'b0);

      for (int t = 0; t < 60; t++) begin
         logic [1:0] sz;
         sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         run_txn(1'($urandom), $urandom, sz, $urandom, int'($urandom_range(0, TIMEOUT + 1)),
                 ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
